// File: rtl/psum_accum_buffer.sv
// Accumulates one filter's per-channel partial-sum map across CI channels, then streams the shifted/ReLU'd/saturated map out.
// Latency: in_valid of a final-channel beat to out_valid is 2 cycles; done follows out_last by 1 cycle.
// Backpressure: none; input beats are accepted every cycle in ACCUM and the output stream cannot be stalled.
module psum_accum_buffer #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 16,
    parameter int OUT_W      = 2,
    parameter int OUT_H      = 2,
    parameter int CI         = 3,
    parameter int FRAC_SHIFT = 0,
    parameter int RELU       = 0
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [ACC_W-1:0]  in_data,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     done,
    output logic                     err
);

    localparam int N  = OUT_W * OUT_H;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (CI > 1) ? $clog2(CI) : 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    // Write-back and re-read of one address are always >= 2 cycles apart only when N >= 4.
    generate
        if (N < 4) begin : g_bad_map_size
            $error("psum_accum_buffer: OUT_W*OUT_H must be >= 4");
        end
        if (CI < 1) begin : g_bad_ci
            $error("psum_accum_buffer: CI must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic                    vld;
        logic                    first;
        logic                    last;
        logic [AW-1:0]           addr;
        logic signed [ACC_W-1:0] dat;
    } s1_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]            ch_cnt_q, ch_cnt_d;
    s1_t                      s1_q, s1_d;
    logic                     busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic signed [ACC_W-1:0]  mem [N];
    logic signed [ACC_W-1:0]  mem_rd_q;
    logic                     mem_we;

    logic signed [ACC_W:0]    sum_wide;
    logic signed [ACC_W-1:0]  sum_sat;
    logic signed [ACC_W-1:0]  sum_sel;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  clamped;

    // Stage 2 add/saturate and stage 3 post-processing datapath.
    always_comb begin
        sum_wide = {mem_rd_q[ACC_W-1], mem_rd_q} + {s1_q.dat[ACC_W-1], s1_q.dat};
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_W-1:0];
        end
        sum_sel = s1_q.first ? s1_q.dat : sum_sat;

        shifted = sum_sel >>> FRAC_SHIFT;
        clamped = shifted;
        if ((RELU != 0) && shifted[ACC_W-1]) begin
            clamped = '0;
        end else if (shifted > OUT_MAX) begin
            clamped = OUT_MAX;
        end else if (shifted < OUT_MIN) begin
            clamped = OUT_MIN;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        busy_d    = busy_q;
        err_d     = err_q;
        done_d    = 1'b0;
        s1_d      = s1_q;
        s1_d.vld  = 1'b0;

        mem_we      = s1_q.vld && !s1_q.last;
        out_valid_d = s1_q.vld && s1_q.last;
        out_last_d  = out_valid_d && (s1_q.addr == AW'(N - 1));
        out_data_d  = out_valid_d ? DATA_W'(clamped) : out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ACCUM;
                    pix_cnt_d = '0;
                    ch_cnt_d  = '0;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                end
                if (in_valid) begin
                    err_d = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (in_valid) begin
                    s1_d.vld   = 1'b1;
                    s1_d.first = (ch_cnt_q == '0);
                    s1_d.last  = (ch_cnt_q == CW'(CI - 1));
                    s1_d.addr  = pix_cnt_q;
                    s1_d.dat   = in_data;
                    if (pix_cnt_q == AW'(N - 1)) begin
                        pix_cnt_d = '0;
                        if (ch_cnt_q == CW'(CI - 1)) begin
                            ch_cnt_d = '0;
                            state_d  = ST_FLUSH;
                        end else begin
                            ch_cnt_d = ch_cnt_q + CW'(1);
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + AW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (start || in_valid) begin
                    err_d = 1'b1;
                end
                // The final pixel is on the output now; done lands one cycle later.
                if (out_valid_q && out_last_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            ch_cnt_q    <= '0;
            s1_q        <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            s1_q        <= s1_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Buffer RAM: contents are never reset, channel 0 always overwrites them.
    always_ff @(posedge clk1) begin
        if (mem_we) begin
            mem[s1_q.addr] <= sum_sel;
        end
        mem_rd_q <= mem[pix_cnt_q];
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Bench for psum_accum_buffer: three instances (plain, ReLU, FRAC_SHIFT=1) share one stimulus stream;
// a reference model pushes expected pixels/done into queues that a negedge monitor pops and compares.
module tb_psum_accum_buffer;

    localparam int NP = 4;
    localparam int NC = 3;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic rst, start, in_valid;
    logic signed [15:0] in_data;
    logic busy [3];
    logic ov [3];
    logic ol [3];
    logic dn [3];
    logic er [3];
    logic signed [7:0] od [3];

    psum_accum_buffer #(.DATA_W(8), .ACC_W(16), .OUT_W(2), .OUT_H(2), .CI(3), .FRAC_SHIFT(0), .RELU(0)) u_plain (
        .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .busy(busy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .done(dn[0]), .err(er[0]));
    psum_accum_buffer #(.DATA_W(8), .ACC_W(16), .OUT_W(2), .OUT_H(2), .CI(3), .FRAC_SHIFT(0), .RELU(1)) u_relu (
        .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .busy(busy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .done(dn[1]), .err(er[1]));
    psum_accum_buffer #(.DATA_W(8), .ACC_W(16), .OUT_W(2), .OUT_H(2), .CI(3), .FRAC_SHIFT(1), .RELU(0)) u_shift (
        .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .busy(busy[2]), .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]), .done(dn[2]), .err(er[2]));

    typedef struct {
        int d0;
        int d1;
        int d2;
        int last;
        int cyc;
    } exp_t;

    exp_t oq [$];
    int   dq [$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_err = 0;
    int   macc [NP];
    int   mpix, mch;
    int   vals [NP][NC];

    always @(posedge clk1) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    function automatic int sat16(int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int pix_out(int acc, int relu, int sh);
        int v;
        v = acc >>> sh;
        if (relu != 0 && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    function automatic void model_beat(int data, int c);
        exp_t e;
        if (mch == 0) macc[mpix] = data;
        else          macc[mpix] = sat16(macc[mpix] + data);
        if (mch == NC - 1) begin
            e.d0   = pix_out(macc[mpix], 0, 0);
            e.d1   = pix_out(macc[mpix], 1, 0);
            e.d2   = pix_out(macc[mpix], 0, 1);
            e.last = (mpix == NP - 1) ? 1 : 0;
            e.cyc  = c + 2;
            oq.push_back(e);
            if (e.last != 0) dq.push_back(c + 3);
        end
        if (mpix == NP - 1) begin
            mpix = 0;
            mch++;
        end else begin
            mpix++;
        end
    endfunction

    // Monitor: every output beat and done pulse must match the head of its queue.
    exp_t me;
    int   med [3];
    always @(negedge clk1) begin
        if (!rst) begin
            if (ov[0] || ov[1] || ov[2]) begin
                if (oq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    me  = oq.pop_front();
                    med = '{me.d0, me.d1, me.d2};
                    chk("out_cycle", cyc, me.cyc);
                    for (int i = 0; i < 3; i++) begin
                        chk($sformatf("out_valid[%0d]", i), int'(ov[i]), 1);
                        chk($sformatf("out_data[%0d]", i), int'(od[i]), med[i]);
                        chk($sformatf("out_last[%0d]", i), int'(ol[i]), me.last);
                    end
                end
            end
            if (dn[0] || dn[1] || dn[2]) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, dq.pop_front());
                    for (int i = 0; i < 3; i++) begin
                        chk($sformatf("done[%0d]", i), int'(dn[i]), 1);
                        chk($sformatf("busy_at_done[%0d]", i), int'(busy[i]), 0);
                    end
                end
            end
        end
    end

    task automatic drive(input bit vld, input int data, input bit modeled);
        @(posedge clk1);
        #1;
        start    = 1'b0;
        in_valid = vld;
        in_data  = 16'(data);
        if (vld && modeled) model_beat(data, cyc);
    endtask

    task automatic do_reset();
        @(posedge clk1);
        #1;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        oq.delete();
        dq.delete();
        @(posedge clk1);
        #1;
        rst = 1'b0;
        exp_err = 0;
        @(negedge clk1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
            chk($sformatf("rst_out_valid[%0d]", i), int'(ov[i]), 0);
            chk($sformatf("rst_out_data[%0d]", i), int'(od[i]), 0);
            chk($sformatf("rst_out_last[%0d]", i), int'(ol[i]), 0);
            chk($sformatf("rst_done[%0d]", i), int'(dn[i]), 0);
            chk($sformatf("rst_err[%0d]", i), int'(er[i]), 0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((oq.size() != 0 || dq.size() != 0) && n < 40) begin
            @(posedge clk1);
            n++;
        end
        chk("drain_within_budget", (n < 40) ? 1 : 0, 1);
        @(negedge clk1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy_after_done[%0d]", i), int'(busy[i]), 0);
            chk($sformatf("err_after_done[%0d]", i), int'(er[i]), exp_err);
        end
    endtask

    task automatic run_filter(input int gmin, input int gmax, input int inject_at, input int abort_at);
        int b;
        @(posedge clk1);
        #1;
        start    = 1'b1;
        in_valid = 1'b0;
        mpix     = 0;
        mch      = 0;
        exp_err  = 0;
        b = 0;
        for (int ch = 0; ch < NC; ch++) begin
            for (int p = 0; p < NP; p++) begin
                if (b == abort_at) begin
                    do_reset();
                    repeat (5) drive(1'b0, 0, 1'b0);
                    return;
                end
                if (b == inject_at) begin
                    @(posedge clk1);
                    #1;
                    start    = 1'b1;
                    in_valid = 1'b0;
                    @(posedge clk1);
                    #1;
                    start   = 1'b0;
                    exp_err = 1;
                    @(negedge clk1);
                    chk("err_on_start_while_busy", int'(er[0]), 1);
                    chk("busy_kept_on_stray_start", int'(busy[0]), 1);
                end
                repeat ($urandom_range(gmax, gmin)) drive(1'b0, 0, 1'b0);
                drive(1'b1, vals[p][ch], 1'b1);
                if (b == 0) begin
                    @(negedge clk1);
                    chk("busy_after_start", int'(busy[0]), 1);
                    chk("err_cleared_by_start", int'(er[0]), 0);
                end
                b++;
            end
        end
        drive(1'b0, 0, 1'b0);
        wait_drain();
    endtask

    task automatic fill_ramp();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < NC; c++)
                vals[p][c] = p + 1;
    endtask

    task automatic fill_zero();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < NC; c++)
                vals[p][c] = 0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        mpix = 0;
        mch = 0;
        do_reset();

        // Ramp map, back-to-back: expect 3,6,9,12.
        fill_ramp();
        run_filter(0, 0, -1, -1);

        // ReLU clamp and positive saturation.
        fill_zero();
        vals[0][0] = -5; vals[0][1] = 2; vals[0][2] = 1;
        for (int c = 0; c < NC; c++) vals[1][c] = 100;
        run_filter(0, 0, -1, -1);

        // Negative saturation after shift, and shift truncation.
        fill_zero();
        for (int c = 0; c < NC; c++) vals[0][c] = -200;
        vals[1][0] = 7;
        run_filter(0, 0, -1, -1);

        // Ramp with 1-3 idle cycles between beats.
        fill_ramp();
        run_filter(1, 3, -1, -1);

        // Stray start mid-ACCUM, then a stray beat in IDLE.
        run_filter(0, 0, 5, -1);
        drive(1'b1, 55, 1'b0);
        drive(1'b0, 0, 1'b0);
        repeat (4) drive(1'b0, 0, 1'b0);
        @(negedge clk1);
        chk("err_sticky_after_idle_beat", int'(er[0]), 1);
        chk("idle_beat_busy", int'(busy[0]), 0);

        // Abort after 5 beats, then a fresh ramp run.
        run_filter(0, 0, -1, 5);
        run_filter(0, 0, -1, -1);

        // Random full-range data with random gaps.
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < NP; p++)
                for (int c = 0; c < NC; c++)
                    vals[p][c] = int'($urandom_range(65535, 0)) - 32768;
            if (k == 0) vals[2] = '{30000, 30000, 30000};
            if (k == 1) vals[3] = '{-30000, -30000, -30000};
            run_filter(0, 2, -1, -1);
        end

        repeat (3) @(posedge clk1);
        chk("queues_empty", oq.size() + dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, got no finish, expected finish");
        $fatal(1);
    end

endmodule
